// File: rtl/n1_pf_pkg.sv
// Shared types for the N1 instruction prefetch unit.
package n1_pf_pkg;

    localparam int N1_PADR_W = 14;
    localparam int N1_INSN_W = 16;

    typedef struct packed {
        logic [N1_PADR_W-1:0] adr;
        logic [N1_INSN_W-1:0] dat;
    } pf_entry_t;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } pf_state_t;

    // Program addresses wrap 3FFF -> 0000 by plain truncation.
    function automatic logic [N1_PADR_W-1:0] pf_adr_inc(input logic [N1_PADR_W-1:0] a);
        return a + 14'd1;
    endfunction

endpackage

// File: rtl/n1_pf_fifo.sv
// Synchronous FIFO of pf_entry_t with a clear input; clear wins over push.
module n1_pf_fifo
    import n1_pf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  pf_entry_t     wdata_i,
    input  logic          pop_i,
    output pf_entry_t     rdata_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    pf_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CW'(DEPTH));
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/n1_prefetch.sv
// N1 instruction prefetch: pipelined Wishbone master feeding a word queue for the IR.
// Optional N1_PF_BYPASS_EN forwards a fresh ack straight to the outputs when the queue is empty.
module n1_prefetch
    import n1_pf_pkg::*;
#(
    parameter int                   DEPTH   = 4,
    parameter logic [N1_PADR_W-1:0] RST_ADR = 14'h0000
) (
    input  logic                 clk_i,
    input  logic                 sync_rst_i,
    output logic                 pbus_cyc_o,
    output logic                 pbus_stb_o,
    output logic [N1_PADR_W-1:0] pbus_adr_o,
    input  logic                 pbus_ack_i,
    input  logic                 pbus_stall_i,
    input  logic [N1_INSN_W-1:0] pbus_dat_i,
    input  logic                 pf_halt_i,
    input  logic                 pf_redirect_i,
    input  logic [N1_PADR_W-1:0] pf_redirect_adr_i,
    output logic                 pf_valid_o,
    output logic [N1_INSN_W-1:0] pf_dat_o,
    output logic [N1_PADR_W-1:0] pf_adr_o,
    input  logic                 fc_ir_capture_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    pf_state_t            state_q, state_d;
    logic [N1_PADR_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]        out_q, out_d;
    logic [CW-1:0]        drop_q, drop_d;

    logic [CW-1:0]        q_cnt, af_cnt;
    logic                 q_empty, q_full, af_empty, af_full;
    pf_entry_t            q_rdata, af_rdata, af_wdata, fresh, head;
    logic                 credit_ok, stb, accept, drop_ack, ack_fresh;
    logic                 valid, take, q_push, q_pop, af_push;
    logic                 unused_ok;

    // Issue side: queued words plus words in flight must fit in the queue.
    always_comb begin
        credit_ok = ({1'b0, q_cnt} + {1'b0, out_q}) < SW'(DEPTH);
        stb       = ~sync_rst_i & (state_q == RUN) & ~pf_halt_i & credit_ok;
        accept    = stb & ~pbus_stall_i;
        af_push   = accept & ~pf_redirect_i;
        af_wdata  = '{adr: ptr_q, dat: '0};
    end

    // Acks from the old stream (or arriving with a redirect) are discarded.
    always_comb begin
        drop_ack  = pbus_ack_i & ((drop_q != '0) | pf_redirect_i);
        ack_fresh = pbus_ack_i & ~drop_ack;
        fresh     = '{adr: af_rdata.adr, dat: pbus_dat_i};
`ifdef N1_PF_BYPASS_EN
        valid  = ~q_empty | ack_fresh;
        head   = q_empty ? fresh : q_rdata;
        take   = fc_ir_capture_i & valid & ~pf_redirect_i;
        q_push = ack_fresh & ~(q_empty & take);
`else
        valid  = ~q_empty;
        head   = q_rdata;
        take   = fc_ir_capture_i & valid & ~pf_redirect_i;
        q_push = ack_fresh;
`endif
        q_pop  = take & ~q_empty;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = RUN;
            RUN:     if (pf_halt_i)  state_d = HALT;
            HALT:    if (!pf_halt_i) state_d = RUN;
            default: state_d = RESET;
        endcase

        ptr_d = ptr_q;
        if (pf_redirect_i)  ptr_d = pf_redirect_adr_i;
        else if (accept)    ptr_d = pf_adr_inc(ptr_q);

        out_d  = out_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pbus_ack_i};
        drop_d = drop_q;
        if (pf_redirect_i)                     drop_d = out_d;
        else if (pbus_ack_i && drop_q != '0)   drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q <= RESET;
            ptr_q   <= RST_ADR;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    n1_pf_fifo #(.DEPTH(DEPTH)) u_queue (
        .clk_i   (clk_i),
        .rst_i   (sync_rst_i),
        .clr_i   (pf_redirect_i),
        .push_i  (q_push),
        .wdata_i (fresh),
        .pop_i   (q_pop),
        .rdata_o (q_rdata),
        .empty_o (q_empty),
        .full_o  (q_full),
        .count_o (q_cnt)
    );

    // Addresses of requests in flight; a redirect abandons them all, so clear it too.
    n1_pf_fifo #(.DEPTH(DEPTH)) u_inflight (
        .clk_i   (clk_i),
        .rst_i   (sync_rst_i),
        .clr_i   (pf_redirect_i),
        .push_i  (af_push),
        .wdata_i (af_wdata),
        .pop_i   (ack_fresh),
        .rdata_o (af_rdata),
        .empty_o (af_empty),
        .full_o  (af_full),
        .count_o (af_cnt)
    );

    assign unused_ok  = ^{af_rdata.dat, af_cnt, af_empty, af_full, q_full};

    assign pbus_stb_o = stb;
    assign pbus_cyc_o = ~sync_rst_i & (stb | (out_q != '0));
    assign pbus_adr_o = ptr_q;
    assign pf_valid_o = valid;
    assign pf_dat_o   = valid ? head.dat : '0;
    assign pf_adr_o   = valid ? head.adr : '0;

    a_cap_needs_valid: assert property (@(posedge clk_i) disable iff (sync_rst_i)
        fc_ir_capture_i |-> pf_valid_o);
    a_out_bound: assert property (@(posedge clk_i) disable iff (sync_rst_i)
        (out_q <= CW'(DEPTH)) && (drop_q <= out_q));
    a_queue_no_ovf: assert property (@(posedge clk_i) disable iff (sync_rst_i)
        !(q_push && q_full && !q_pop && !pf_redirect_i));
    a_fresh_has_adr: assert property (@(posedge clk_i) disable iff (sync_rst_i)
        ack_fresh |-> !af_empty);

endmodule

// File: tb/tb_n1_prefetch.sv
// Bench for n1_prefetch: table-driven reset/backpressure run, directed corner sequences, random run vs a model.
module tb_n1_prefetch;
    localparam int DEPTH = 4;
`ifdef N1_PF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst;
    logic        cyc, stb, ack, stall, halt, redir, valid, cap, cap_en;
    logic [13:0] adr, redir_adr, padr;
    logic [15:0] dat, pdat;

    assign cap = cap_en & valid;

    n1_prefetch #(.DEPTH(DEPTH), .RST_ADR(14'h0000)) dut (
        .clk_i(clk), .sync_rst_i(rst),
        .pbus_cyc_o(cyc), .pbus_stb_o(stb), .pbus_adr_o(adr),
        .pbus_ack_i(ack), .pbus_stall_i(stall), .pbus_dat_i(dat),
        .pf_halt_i(halt), .pf_redirect_i(redir), .pf_redirect_adr_i(redir_adr),
        .pf_valid_o(valid), .pf_dat_o(pdat), .pf_adr_o(padr),
        .fc_ir_capture_i(cap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fdat(input logic [13:0] a);
        return {a, 2'b01} ^ 16'h5A3C;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Wishbone slave: in-order acks with configurable rate, data derived from address.
    logic [13:0] pend[$];
    logic [13:0] acc_log[$];
    logic [13:0] cap_log[$];
    int  acc_total = 0;
    int  ack_pct = 100, stall_pct = 0;
    bit  ack_en = 1, force_stall = 0;
    bit  s_acc, s_ack, s_rst;
    logic [13:0] s_adr;

    always @(negedge clk) begin
        s_acc = cyc & stb & ~stall;
        s_ack = ack;
        s_adr = adr;
        s_rst = rst;
    end

    always @(posedge clk) begin
        #1;
        if (s_rst) pend.delete();
        else begin
            if (s_ack && pend.size() > 0) void'(pend.pop_front());
            if (s_acc) begin
                pend.push_back(s_adr);
                acc_log.push_back(s_adr);
                acc_total++;
            end
        end
        if (!s_rst && ack_en && pend.size() > 0 && ($urandom_range(99) < ack_pct)) begin
            ack = 1'b1;
            dat = fdat(pend[0]);
        end else begin
            ack = 1'b0;
            dat = 16'($urandom);
        end
        stall = force_stall | ($urandom_range(99) < stall_pct);
    end

    // Every word the IR takes must carry the data belonging to its address.
    always @(negedge clk) begin
        if (!rst && cap && !redir) begin
            cap_log.push_back(padr);
            chk("cap_dat", pdat, fdat(padr));
        end
    end

    // Reference model for the random phase: program-order stream and bus accounting.
    bit          rnd_on = 0;
    logic [13:0] m_ptr, m_exp;
    int          m_out, ncap;
    bit          post_redir, halt_prev;

    always @(negedge clk) begin
        if (rnd_on) begin
            if (rst) begin
                m_ptr = 14'h0; m_exp = 14'h0; m_out = 0;
                post_redir = 0; halt_prev = 0;
            end else begin
                if (cyc & stb & ~stall) chk("rnd_issue_adr", adr, m_ptr);
                if (cap && !redir) begin
                    chk("rnd_cap_adr", padr, m_exp);
                    m_exp = m_exp + 14'd1;
                    ncap++;
                end
                if (post_redir) chk("rnd_redir_valid", valid, 1'b0);
                if (halt_prev && halt) chk("rnd_halt_stb", stb, 1'b0);
                if (m_out > 0) chk("rnd_cyc_held", cyc, 1'b1);
                if (stb) chk("rnd_stb_cyc", cyc, 1'b1);
                m_out = m_out + int'(cyc & stb & ~stall) - int'(ack);
                chk("rnd_out_bound", (m_out >= 0) && (m_out <= DEPTH), 1'b1);
                if (redir) begin
                    m_ptr = redir_adr;
                    m_exp = redir_adr;
                end else if (cyc & stb & ~stall) m_ptr = m_ptr + 14'd1;
                post_redir = redir;
                halt_prev  = halt;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        redir = 1'b0;
        halt = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          cap;
        bit          cyc;
        bit          stb;
        logic [13:0] adr;
        bit          valid;
        logic [13:0] padr;
    } vec_t;
    vec_t tbl[11];

    initial begin
        bit got;
        // Reset fetch without captures, zero-wait slave: fill to DEPTH, then one capture frees one slot.
        tbl[0]  = '{0, 0, 0, 14'h0, 0,   14'h0};
        tbl[1]  = '{0, 1, 1, 14'h0, 0,   14'h0};
        tbl[2]  = '{0, 1, 1, 14'h1, BYP, 14'h0};
        tbl[3]  = '{0, 1, 1, 14'h2, 1,   14'h0};
        tbl[4]  = '{0, 1, 1, 14'h3, 1,   14'h0};
        tbl[5]  = '{0, 1, 0, 14'h4, 1,   14'h0};
        tbl[6]  = '{0, 0, 0, 14'h4, 1,   14'h0};
        tbl[7]  = '{1, 0, 0, 14'h4, 1,   14'h0};
        tbl[8]  = '{0, 1, 1, 14'h4, 1,   14'h1};
        tbl[9]  = '{0, 1, 0, 14'h5, 1,   14'h1};
        tbl[10] = '{0, 0, 0, 14'h5, 1,   14'h1};

        rst = 1'b1; stall = 1'b0; halt = 1'b0; redir = 1'b0; redir_adr = '0;
        cap_en = 1'b0; ack = 1'b0; dat = '0;

        do_reset();
        for (int k = 0; k < 11; k++) begin
            cap_en = tbl[k].cap;
            @(negedge clk);
            chk($sformatf("tbl%0d_cyc", k),   cyc,   tbl[k].cyc);
            chk($sformatf("tbl%0d_stb", k),   stb,   tbl[k].stb);
            chk($sformatf("tbl%0d_adr", k),   adr,   tbl[k].adr);
            chk($sformatf("tbl%0d_valid", k), valid, tbl[k].valid);
            chk($sformatf("tbl%0d_padr", k),  padr,  tbl[k].padr);
            step();
        end

        // Reset fetch with capture held: back-to-back issue and in-order delivery.
        cap_en = 1'b1;
        do_reset();
        acc_log.delete(); cap_log.delete();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k >= 1) chk("rf_stb", stb, 1'b1);
            if (k == 2) chk("rf_valid_early", valid, BYP);
            if (k == 3) chk("rf_valid", valid, 1'b1);
            step();
        end
        chk("rf_ncap", cap_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) if (i < cap_log.size()) chk("rf_cap_adr", cap_log[i], 14'(i));
        for (int i = 0; i < 6; i++) if (i < acc_log.size()) chk("rf_acc_adr", acc_log[i], 14'(i));

        // Stall held: address stable, no pointer advance.
        cap_en = 1'b0; stall = 1'b1; force_stall = 1'b1;
        do_reset();
        acc_log.delete();
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_stb", stb, 1'b1);
            chk("stall_adr", adr, 14'h0);
            step();
        end
        stall = 1'b0; force_stall = 1'b0;
        repeat (4) step();
        chk("stall_nacc", acc_log.size() >= 2, 1'b1);
        for (int i = 0; i < 2; i++) if (i < acc_log.size()) chk("stall_acc_adr", acc_log[i], 14'(i));

        // Redirect with three requests in flight: their acks must be dropped.
        cap_en = 1'b0; ack_en = 0;
        do_reset();
        acc_total = 0;
        for (int i = 0; i < 20 && acc_total < 3; i++) step();
        chk("stale_setup", acc_total, 3);
        stall = 1'b1; force_stall = 1'b1; redir = 1'b1; redir_adr = 14'h0100;
        step();
        redir = 1'b0; stall = 1'b0; force_stall = 1'b0; ack_en = 1;
        @(negedge clk);
        chk("stale_valid_low", valid, 1'b0);
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid) begin got = 1; break; end
        end
        chk("stale_wait", got, 1'b1);
        chk("stale_adr", padr, 14'h0100);
        chk("stale_dat", pdat, fdat(14'h0100));

        // Wrap-around of the fetch pointer.
        step();
        cap_en = 1'b1; stall = 1'b1; force_stall = 1'b1; redir = 1'b1; redir_adr = 14'h3FFE;
        acc_log.delete(); cap_log.delete();
        step();
        redir = 1'b0; stall = 1'b0; force_stall = 1'b0;
        repeat (12) step();
        chk("wrap_nacc", acc_log.size() >= 3, 1'b1);
        if (acc_log.size() >= 3) begin
            chk("wrap_acc0", acc_log[0], 14'h3FFE);
            chk("wrap_acc1", acc_log[1], 14'h3FFF);
            chk("wrap_acc2", acc_log[2], 14'h0000);
        end
        chk("wrap_ncap", cap_log.size() >= 3, 1'b1);
        if (cap_log.size() >= 3) begin
            chk("wrap_cap0", cap_log[0], 14'h3FFE);
            chk("wrap_cap1", cap_log[1], 14'h3FFF);
            chk("wrap_cap2", cap_log[2], 14'h0000);
        end

        // Redirect coincident with capture and ack.
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack && valid) begin got = 1; break; end
            step();
        end
        chk("rca_setup", got, 1'b1);
        redir = 1'b1; redir_adr = 14'h0200;
        cap_log.delete();
        step();
        redir = 1'b0;
        @(negedge clk);
        chk("rca_flush", valid, 1'b0);
        repeat (10) step();
        chk("rca_ncap", cap_log.size() >= 2, 1'b1);
        if (cap_log.size() >= 2) begin
            chk("rca_cap0", cap_log[0], 14'h0200);
            chk("rca_cap1", cap_log[1], 14'h0201);
        end

        // Halt, with a redirect while halted.
        halt = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("halt_stb", stb, 1'b0);
        step();
        redir = 1'b1; redir_adr = 14'h0300;
        acc_log.delete();
        @(negedge clk);
        chk("halt_redir_stb", stb, 1'b0);
        step();
        redir = 1'b0; halt = 1'b0;
        repeat (8) step();
        chk("halt_nacc", acc_log.size() >= 1, 1'b1);
        if (acc_log.size() >= 1) chk("halt_resume_adr", acc_log[0], 14'h0300);

        // Random phase against the model.
        rnd_on = 1; ncap = 0;
        ack_pct = 70; stall_pct = 20; cap_en = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cap_en    = ($urandom_range(99) < 70);
            halt      = halt ? ($urandom_range(99) < 80) : ($urandom_range(99) < 4);
            redir     = ($urandom_range(99) < 2);
            redir_adr = ($urandom_range(3) == 0) ? 14'(14'h3FFC + $urandom_range(3))
                                                 : 14'($urandom);
            step();
        end
        redir = 1'b0; halt = 1'b0;
        @(negedge clk);
        rnd_on = 0;
        chk("rnd_progress", ncap > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
